// File: rtl/inst_rom_pkg.sv
// Shared constants for the instruction ROM: depth, FSM encodings and the
// helper that left-justifies a partially assembled word.
package inst_rom_pkg;

  localparam int ROM_DEPTH_LOG2 = 10;

  localparam logic [1:0] ROM_IDLE = 2'd0;
  localparam logic [1:0] ROM_LOAD = 2'd1;
  localparam logic [1:0] ROM_RUN  = 2'd2;

  localparam logic [31:0] NOP_INST = 32'h0;

  // sr holds the bytes received so far right-justified; n_prev is how many
  // bytes preceded the newest one. Moves them to the top, zero-filling below.
  function automatic logic [31:0] pad_word(input logic [31:0] sr,
                                           input logic [1:0]  n_prev);
    logic [31:0] w;
    case (n_prev)
      2'd0:    w = {sr[7:0],  24'h0};
      2'd1:    w = {sr[15:0], 16'h0};
      2'd2:    w = {sr[23:0], 8'h0};
      default: w = sr;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/inst_rom_byte_packer.sv
// Assembles big-endian load bytes into 32-bit words; a final short word is
// zero-padded in its low bytes and emitted together with its last byte.
module rom_byte_packer
  import inst_rom_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clear,
  input  logic        i_accept,
  input  logic [7:0]  i_byte,
  input  logic        i_last,
  output logic        o_word_vld,
  output logic [31:0] o_word
);

  logic [31:0] r_sr;
  logic [1:0]  r_byte_cnt;
  logic [31:0] w_sr;

  assign w_sr       = {r_sr[23:0], i_byte};
  assign o_word_vld = i_accept && ((r_byte_cnt == 2'd3) || i_last);
  assign o_word     = pad_word(w_sr, r_byte_cnt);

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_sr       <= '0;
      r_byte_cnt <= '0;
    end else if (i_accept) begin
      if (o_word_vld) begin
        r_sr       <= '0;
        r_byte_cnt <= '0;
      end else begin
        r_sr       <= w_sr;
        r_byte_cnt <= r_byte_cnt + 2'd1;
      end
    end
  end

endmodule

// File: rtl/inst_rom.sv
// Instruction memory with zero-latency fetch and a byte-serial boot loader
// that holds the core in reset until a complete image has been written.
module inst_rom
  import inst_rom_pkg::*;
#(
  parameter int INST_W     = 32,
  parameter int PC_W       = 32,
  parameter int DEPTH_LOG2 = ROM_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  romCe,
  input  logic [PC_W-1:0]       pc,
  output logic [INST_W-1:0]     inst,
  input  logic                  ldStart,
  input  logic                  ldValid,
  input  logic [7:0]            ldByte,
  input  logic                  ldLast,
  output logic                  ldReady,
  output logic                  cpuRst,
  output logic                  loadDone,
  output logic                  ovf,
  output logic [DEPTH_LOG2:0]   wordCnt
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [1:0]          r_state;
  logic [DEPTH_LOG2:0] r_wr_ptr;
  logic                r_ovf;
  logic [INST_W-1:0]   r_mem [DEPTH];

  logic                w_accept;
  logic                w_start;
  logic                w_full;
  logic                w_word_vld;
  logic [31:0]         w_word;
  logic [PC_W-1:0]     w_word_addr;
  logic                w_in_range;

  assign ldReady  = (r_state == ROM_LOAD);
  assign cpuRst   = (r_state != ROM_RUN);
  assign loadDone = (r_state == ROM_RUN);
  assign ovf      = r_ovf;
  assign wordCnt  = r_wr_ptr;

  assign w_accept = ldValid && ldReady;
  // A start pulse only (re)enters LOAD from IDLE or RUN.
  assign w_start  = ldStart && (r_state != ROM_LOAD);
  assign w_full   = r_wr_ptr[DEPTH_LOG2];

  rom_byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (w_start),
    .i_accept   (w_accept),
    .i_byte     (ldByte),
    .i_last     (ldLast),
    .o_word_vld (w_word_vld),
    .o_word     (w_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ROM_IDLE;
    end else begin
      case (r_state)
        ROM_IDLE: if (ldStart) r_state <= ROM_LOAD;
        ROM_LOAD: if (w_accept && ldLast) r_state <= ROM_RUN;
        ROM_RUN:  if (ldStart) r_state <= ROM_LOAD;
        default:  r_state <= ROM_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || w_start) begin
      r_wr_ptr <= '0;
      r_ovf    <= 1'b0;
    end else if (w_word_vld) begin
      if (w_full) r_ovf <= 1'b1;
      else        r_wr_ptr <= r_wr_ptr + 1'b1;
    end
  end

  // Memory is deliberately left out of reset so a board reset keeps the image.
  always_ff @(posedge clk) begin
    if (!rst && w_word_vld && !w_full)
      r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= INST_W'(w_word);
  end

  assign w_word_addr = pc >> 2;
  assign w_in_range  = (w_word_addr[PC_W-1:DEPTH_LOG2] == '0);
  assign inst = (romCe && w_in_range) ? r_mem[w_word_addr[DEPTH_LOG2-1:0]]
                                      : INST_W'(NOP_INST);

endmodule

// File: tb/tb_inst_rom.sv
// Scoreboard bench for inst_rom: loader stimulus pushes expected words, the
// fetch port pops and compares them. Runs at a 4-word depth to reach overflow.
module tb_inst_rom;

  localparam int DL2   = 2;
  localparam int DEPTH = 1 << DL2;

  logic          clk = 1'b0;
  logic          rst, romCe, ldStart, ldValid, ldLast;
  logic [31:0]   pc;
  logic [7:0]    ldByte;
  logic [31:0]   inst;
  logic          ldReady, cpuRst, loadDone, ovf;
  logic [DL2:0]  wordCnt;

  int            n_checks = 0;
  int            n_errors = 0;

  logic [7:0]    stim [0:31];
  int            addr_q [$];
  logic [31:0]   data_q [$];
  logic [31:0]   model_mem [0:DEPTH-1];
  int            exp_cnt;
  logic          exp_ovf;

  inst_rom #(.INST_W(32), .PC_W(32), .DEPTH_LOG2(DL2)) dut (
    .clk(clk), .rst(rst), .romCe(romCe), .pc(pc), .inst(inst),
    .ldStart(ldStart), .ldValid(ldValid), .ldByte(ldByte), .ldLast(ldLast),
    .ldReady(ldReady), .cpuRst(cpuRst), .loadDone(loadDone), .ovf(ovf),
    .wordCnt(wordCnt)
  );

  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one full image from stim[0:n-1]; the model fills the scoreboard.
  task automatic send_load(input int n);
    logic [31:0] mw;
    int          mcnt;
    int          wptr;
    mw = '0; mcnt = 0; wptr = 0; exp_ovf = 1'b0;
    ldStart = 1'b1;
    step();
    ldStart = 1'b0;
    chk_val("ready_in_load", 32'(ldReady), 32'd1);
    for (int i = 0; i < n; i++) begin
      ldValid = 1'b1;
      ldByte  = stim[i];
      ldLast  = (i == n - 1);
      mw   = {mw[23:0], stim[i]};
      mcnt = mcnt + 1;
      if (mcnt == 4 || i == n - 1) begin
        mw = mw << (8 * (4 - mcnt));
        if (wptr < DEPTH) begin
          addr_q.push_back(wptr);
          data_q.push_back(mw);
          model_mem[wptr] = mw;
          wptr++;
        end else begin
          exp_ovf = 1'b1;
        end
        mw = '0; mcnt = 0;
      end
      step();
    end
    ldValid = 1'b0;
    ldLast  = 1'b0;
    exp_cnt = wptr;
    chk_val("loadDone", 32'(loadDone), 32'd1);
    chk_val("cpuRst_run", 32'(cpuRst), 32'd0);
    chk_val("wordCnt", 32'(wordCnt), 32'(exp_cnt));
    chk_val("ovf", 32'(ovf), 32'(exp_ovf));
  endtask

  task automatic drain();
    while (addr_q.size() > 0) begin
      int          a;
      logic [31:0] d;
      a = addr_q.pop_front();
      d = data_q.pop_front();
      romCe = 1'b1;
      pc    = 32'(a) << 2;
      #1;
      chk_val($sformatf("mem%0d", a), inst, d);
    end
    romCe = 1'b0;
  endtask

  initial begin
    rst = 1'b1; romCe = 1'b0; pc = '0; ldStart = 1'b0;
    ldValid = 1'b0; ldByte = '0; ldLast = 1'b0;
    step();
    step();
    chk_val("rst_cpuRst", 32'(cpuRst), 32'd1);
    chk_val("rst_ldReady", 32'(ldReady), 32'd0);
    chk_val("rst_loadDone", 32'(loadDone), 32'd0);
    chk_val("rst_wordCnt", 32'(wordCnt), 32'd0);
    chk_val("rst_ovf", 32'(ovf), 32'd0);
    chk_val("rst_inst", inst, 32'h0);
    rst = 1'b0;

    // Bytes offered while idle must be ignored.
    ldValid = 1'b1; ldByte = 8'h5A; ldLast = 1'b1;
    step();
    ldValid = 1'b0; ldLast = 1'b0;
    chk_val("idle_ignore_done", 32'(loadDone), 32'd0);
    chk_val("idle_ignore_cnt", 32'(wordCnt), 32'd0);

    stim[0] = 8'h34; stim[1] = 8'h08; stim[2] = 8'h00; stim[3] = 8'h05;
    stim[4] = 8'h24; stim[5] = 8'h09; stim[6] = 8'h00; stim[7] = 8'h07;
    send_load(8);
    drain();
    romCe = 1'b1; pc = 32'h4; #1;
    chk_val("fetch_pc4", inst, 32'h24090007);
    pc = 32'h6; #1;
    chk_val("fetch_pc6", inst, model_mem[1]);
    pc = 32'h0000_1000; #1;
    chk_val("fetch_oor", inst, 32'h0);
    romCe = 1'b0; pc = 32'h4; #1;
    chk_val("fetch_ce0", inst, 32'h0);

    stim[0] = 8'hAA; stim[1] = 8'hBB;
    send_load(2);
    drain();
    romCe = 1'b1; pc = 32'h4; #1;
    chk_val("partial_keeps_w1", inst, model_mem[1]);
    romCe = 1'b0;

    for (int i = 0; i < 20; i++) stim[i] = 8'(8'h10 + i);
    send_load(20);
    drain();
    romCe = 1'b1; pc = 32'h10; #1;
    chk_val("fetch_oor_small", inst, 32'h0);
    romCe = 1'b0;

    ldStart = 1'b1;
    step();
    ldStart = 1'b0;
    chk_val("reload_cpuRst", 32'(cpuRst), 32'd1);
    chk_val("reload_ldReady", 32'(ldReady), 32'd1);
    chk_val("reload_loadDone", 32'(loadDone), 32'd0);
    chk_val("reload_ovf_clr", 32'(ovf), 32'd0);
    chk_val("reload_cnt_clr", 32'(wordCnt), 32'd0);
    ldValid = 1'b1; ldByte = 8'h11;
    step();
    ldByte = 8'h22;
    step();
    ldValid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_val("midrst_ldReady", 32'(ldReady), 32'd0);
    chk_val("midrst_cpuRst", 32'(cpuRst), 32'd1);
    chk_val("midrst_loadDone", 32'(loadDone), 32'd0);
    romCe = 1'b1; pc = 32'h0; #1;
    chk_val("midrst_mem0", inst, model_mem[0]);
    romCe = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/inst_rom.md
Name: inst_rom

Overview:
Instruction-memory responder for the MIPS core. It answers the core's fetch interface (romCe, pc -> inst) with the addressed instruction word in the same cycle. It also contains a byte-serial boot loader that fills the memory and holds the core in reset until loading completes. It sits beside the MIPS top in the SoC wrapper; its cpuRst output drives the core's rst input.

Parameters:
INST_W, 32, instruction word width (matches INST_LENGTH)
PC_W, 32, program counter width (matches PC_LENGTH)
DEPTH_LOG2, 10, log2 of the memory depth in words (1024 words = 4 KiB)

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
romCe  input  1  fetch enable from the core
pc  input  PC_W  byte address from the core
inst  output  INST_W  instruction word returned to the core
ldStart  input  1  one-cycle pulse that begins a (re)load
ldValid  input  1  ldByte is valid this cycle
ldByte  input  8  load data byte, big-endian within each word
ldLast  input  1  qualifies ldByte as the final byte of the image
ldReady  output  1  loader accepts a byte this cycle
cpuRst  output  1  reset to the core, active-high
loadDone  output  1  image is loaded and the core is running
ovf  output  1  image exceeded the memory depth; excess bytes dropped
wordCnt  output  DEPTH_LOG2+1  number of words written by the last load

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: state=IDLE, ldReady=0, cpuRst=1, loadDone=0, ovf=0, wordCnt=0, byte counter=0, shift register=0. Memory contents are not cleared by reset.
- Fetch path (combinational, zero latency):
  - inst = mem[pc[DEPTH_LOG2+1:2]] when romCe=1; inst = 0 when romCe=0.
  - pc[1:0] is ignored.
  - If pc bits above DEPTH_LOG2+1 are nonzero, inst = 0 (NOP).
  - A read and a write to the same word in the same cycle return the old contents.
- FSM states: IDLE, LOAD, RUN.
  - IDLE: cpuRst=1, ldReady=0. ldStart -> LOAD.
  - LOAD: cpuRst=1, ldReady=1. On entry, wrPtr=0, byteCnt=0, ovf=0, wordCnt=0.
  - RUN: cpuRst=0, loadDone=1, ldReady=0. ldStart -> LOAD; cpuRst rises in the cycle after the pulse and loadDone drops in the same cycle.
- Byte acceptance in LOAD: a byte is accepted when ldValid & ldReady.
  - Each accepted byte shifts into the word register MSB-first; byteCnt increments modulo 4.
  - On the 4th byte: write the assembled word to mem[wrPtr], then wrPtr++ and wordCnt++.
- ldLast on an accepted byte:
  - Any unfilled low bytes are zero-padded and the partial word is written the same cycle.
  - The FSM goes to RUN on the next edge.
  - With byteCnt=0 and no pending bytes, nothing extra is written.
- Full memory: when wrPtr has reached 2^DEPTH_LOG2 and another word would be written:
  - the write is dropped and ovf=1 (sticky until the next ldStart);
  - bytes continue to be accepted and discarded until ldLast.
- Simultaneous events:
  - ldStart during LOAD is ignored.
  - ldValid in IDLE or RUN is ignored (ldReady=0).
  - rst has priority over everything.
- Reset mid-load: returns to IDLE with cpuRst=1. Partially written memory is retained but not valid until the next complete load.

Decomposition:
- Shared header MIPS.vh gains:
  - `ROM_DEPTH_LOG2
  - state encodings `ROM_IDLE=2'd0, `ROM_LOAD=2'd1, `ROM_RUN=2'd2
  - `NOP_INST=32'h0
- One natural sub-module, rom_byte_packer: the byte shift register plus byteCnt. It emits wordValid and word, applying the ldLast padding.
- The memory array and FSM stay in inst_rom.

Test Plan:
- Reset: rst=1 for 2 cycles -> cpuRst=1, ldReady=0, loadDone=0, wordCnt=0; inst=0 with romCe=0.
- Normal load:
  - Stimulus: ldStart, then bytes 34 08 00 05 24 09 00 07, with ldLast on the final byte.
  - Required: mem[0]=32'h34080005, mem[1]=32'h24090007, wordCnt=2; loadDone=1 and cpuRst=0 on the cycle after the last byte.
  - Then romCe=1, pc=4 -> inst=32'h24090007 in the same cycle.
- Partial word: ldStart, then bytes AA BB with ldLast on BB -> mem[0]=32'hAABB0000, wordCnt=1.
- Overflow:
  - Stimulus: DEPTH_LOG2=2 in the bench; load 20 bytes.
  - Required: wordCnt=4, ovf=1, mem[3] holds the 4th word; bytes 17-20 are dropped and the FSM reaches RUN on ldLast.
- Fetch edge cases: romCe=1 with pc=32'h00001000 (out of range at default depth) -> inst=0. pc=32'h6 -> returns word 1.
- Reload and reset: in RUN, pulse ldStart -> cpuRst=1 on the next cycle and ldReady=1. Assert rst after 2 bytes -> state IDLE, ldReady=0, cpuRst=1, and mem[0] keeps its old value.
